// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: shift-add multiplier and restoring divider, one bit per clock.
// Results land in hi/lo only at FIX, on divide-by-zero, or on MTHI/MTLO writes.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]      CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0]      CNT_LAST = CW'(1);
  localparam logic [CW-1:0]      CNT_ZERO = CW'(0);
  localparam logic [WIDTH-1:0]   ZERO_W   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0]   ONES_W   = {WIDTH{1'b1}};
  localparam logic [2*WIDTH-1:0] ZERO_2W  = {(2*WIDTH){1'b0}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             state_r, state_nx_s;
  logic [CW-1:0]      cnt_r;
  logic               is_div_r, neg_lo_r, neg_hi_r;
  logic [WIDTH-1:0]   acc_hi_r, acc_lo_r, opb_r;
  logic               dbz_s, sa_s, sb_s, busy_nx_s, done_nx_s;
  logic [WIDTH-1:0]   mag_a_s, mag_b_s, quo_fix_s, rem_fix_s;
  logic [WIDTH:0]     mul_sum_s, div_shift_s, div_diff_s;
  logic [2*WIDTH-1:0] prod_fix_s;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_r <= S_IDLE;
    else        state_r <= state_nx_s;
  end

  // Next-state logic
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start && dbz_s) state_nx_s = S_DONE;
        else if (start)     state_nx_s = S_RUN;
        else                state_nx_s = S_IDLE;
      end
      S_RUN: begin
        if (cnt_r == CNT_LAST) state_nx_s = S_FIX;
        else                   state_nx_s = S_RUN;
      end
      S_FIX:   state_nx_s = S_DONE;
      S_DONE:  state_nx_s = S_IDLE;
      default: state_nx_s = S_IDLE;
    endcase
  end

  // Output decode from the next state so busy/done can be registered
  always_comb begin
    busy_nx_s = 1'b0;
    done_nx_s = 1'b0;
    case (state_nx_s)
      S_RUN:   busy_nx_s = 1'b1;
      S_FIX:   busy_nx_s = 1'b1;
      S_DONE:  done_nx_s = 1'b1;
      default: begin
        busy_nx_s = 1'b0;
        done_nx_s = 1'b0;
      end
    endcase
  end

  // Operand magnitudes, per-bit iteration step and final sign correction
  always_comb begin
    sa_s        = op[0] & a[WIDTH-1];
    sb_s        = op[0] & b[WIDTH-1];
    dbz_s       = op[1] & (b == ZERO_W);
    mag_a_s     = sa_s ? (ZERO_W - a) : a;
    mag_b_s     = sb_s ? (ZERO_W - b) : b;
    mul_sum_s   = {1'b0, acc_hi_r} + (acc_lo_r[0] ? {1'b0, opb_r} : {1'b0, ZERO_W});
    div_shift_s = {acc_hi_r, acc_lo_r[WIDTH-1]};
    div_diff_s  = div_shift_s - {1'b0, opb_r};
    prod_fix_s  = neg_lo_r ? (ZERO_2W - {acc_hi_r, acc_lo_r}) : {acc_hi_r, acc_lo_r};
    quo_fix_s   = neg_lo_r ? (ZERO_W - acc_lo_r) : acc_lo_r;
    rem_fix_s   = neg_hi_r ? (ZERO_W - acc_hi_r) : acc_hi_r;
  end

  // Datapath: operand latch, iteration, result write-back, MTHI/MTLO
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r       <= CNT_ZERO;
      is_div_r    <= 1'b0;
      neg_lo_r    <= 1'b0;
      neg_hi_r    <= 1'b0;
      acc_hi_r    <= ZERO_W;
      acc_lo_r    <= ZERO_W;
      opb_r       <= ZERO_W;
      hi          <= ZERO_W;
      lo          <= ZERO_W;
      div_by_zero <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      busy <= busy_nx_s;
      done <= done_nx_s;
      case (state_r)
        S_IDLE: begin
          if (start) begin
            cnt_r       <= CNT_INIT;
            is_div_r    <= op[1];
            neg_lo_r    <= sa_s ^ sb_s;
            neg_hi_r    <= sa_s;
            acc_hi_r    <= ZERO_W;
            acc_lo_r    <= mag_a_s;
            opb_r       <= mag_b_s;
            div_by_zero <= dbz_s;
            if (dbz_s) begin
              hi <= a;
              lo <= ONES_W;
            end
          end else begin
            if (hi_we) hi <= a;
            if (lo_we) lo <= a;
          end
        end
        S_RUN: begin
          cnt_r <= cnt_r - CNT_LAST;
          if (is_div_r) begin
            // Restoring step: keep the difference only when it did not borrow
            if (!div_diff_s[WIDTH]) begin
              acc_hi_r <= div_diff_s[WIDTH-1:0];
              acc_lo_r <= {acc_lo_r[WIDTH-2:0], 1'b1};
            end else begin
              acc_hi_r <= div_shift_s[WIDTH-1:0];
              acc_lo_r <= {acc_lo_r[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc_hi_r <= mul_sum_s[WIDTH:1];
            acc_lo_r <= {mul_sum_s[0], acc_lo_r[WIDTH-1:1]};
          end
        end
        S_FIX: begin
          if (is_div_r) begin
            hi <= rem_fix_s;
            lo <= quo_fix_s;
          end else begin
            hi <= prod_fix_s[2*WIDTH-1:WIDTH];
            lo <= prod_fix_s[WIDTH-1:0];
          end
        end
        S_DONE: begin
          if (hi_we) hi <= a;
          if (lo_we) lo <= a;
        end
        default: cnt_r <= CNT_ZERO;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed scoreboard bench for muldiv_unit: expected hi/lo/div_by_zero/latency are queued
// when an operation is launched and compared when done is observed.
module tb_muldiv_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start, hi_we, lo_we;
  logic [1:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk(input logic [31:0] h, input logic [31:0] l, input logic z, input int lat);
    exp_t e;
    e.hi = h; e.lo = l; e.dbz = z; e.lat = lat;
    return e;
  endfunction

  // Reference arithmetic using native 64-bit operators
  function automatic exp_t model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t        e;
    logic [63:0] p;
    longint      sx, sy, q, r;
    e.dbz = 1'b0;
    e.lat = W + 1;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (o[1] && y == 32'd0) begin
      e.hi = x; e.lo = 32'hFFFFFFFF; e.dbz = 1'b1; e.lat = 0;
    end else begin
      case (o)
        2'b00: begin p = {32'd0, x} * {32'd0, y}; e.hi = p[63:32]; e.lo = p[31:0]; end
        2'b01: begin p = sx * sy; e.hi = p[63:32]; e.lo = p[31:0]; end
        2'b10: begin e.lo = x / y; e.hi = x % y; end
        default: begin q = sx / sy; r = sx % sy; e.lo = q[31:0]; e.hi = r[31:0]; end
      endcase
    end
    return e;
  endfunction

  // Launch one operation, optionally disturb it after edge 'disturb', and check the result
  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input exp_t e, input int disturb);
    logic [31:0] hold_hi, hold_lo;
    int          n, extra;
    exp_t        got;
    sb.push_back(e);
    hold_hi = hi;
    hold_lo = lo;
    start = 1'b1; op = o; a = x; b = y;
    tick();
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    a = $urandom; b = $urandom;
    n = 0;
    while (done !== 1'b1 && n < 80) begin
      check("busy_run", busy, 1);
      check("hi_hold", hi, hold_hi);
      check("lo_hold", lo, hold_lo);
      if (n == disturb) begin
        start = 1'b1; op = 2'b10; a = 32'h55; b = 32'h3; hi_we = 1'b1; lo_we = 1'b1;
      end
      tick();
      n++;
      start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    end
    check("done_seen", done, 1);
    got = sb.pop_front();
    check("latency", n, got.lat);
    check("busy_at_done", busy, 0);
    check("hi", hi, got.hi);
    check("lo", lo, got.lo);
    check("div_by_zero", div_by_zero, got.dbz);
    tick();
    check("done_pulse", done, 0);
    check("busy_idle", busy, 0);
    extra = 0;
    repeat (40) begin
      tick();
      if (done === 1'b1) extra++;
    end
    check("stray_done", extra, 0);
  endtask

  initial begin
    int          extra;
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    reset = 1'b0; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = 2'b00; a = 32'd0; b = 32'd0;
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dbz", div_by_zero, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    tick();

    // MTHI / MTLO in IDLE
    hi_we = 1'b1; a = 32'h1234; tick(); hi_we = 1'b0;
    check("mthi_hi", hi, 32'h1234);
    check("mthi_lo", lo, 32'h0);
    lo_we = 1'b1; a = 32'h5678; tick(); lo_we = 1'b0;
    check("mtlo_lo", lo, 32'h5678);
    check("mtlo_hi", hi, 32'h1234);
    hi_we = 1'b1; lo_we = 1'b1; a = 32'hABCD; tick(); hi_we = 1'b0; lo_we = 1'b0;
    check("mtboth_hi", hi, 32'hABCD);
    check("mtboth_lo", lo, 32'hABCD);

    // start wins over hi_we/lo_we in the same IDLE cycle (hi_hold inside do_op)
    hi_we = 1'b1; lo_we = 1'b1;
    do_op(2'b00, 32'hFFFFFFFF, 32'd2, mk(32'd1, 32'hFFFFFFFE, 1'b0, 33), -1);
    do_op(2'b01, 32'hFFFFFFFD, 32'd5, mk(32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 33), -1);
    do_op(2'b01, 32'hFFFFFFFC, 32'hFFFFFFFC, mk(32'd0, 32'd16, 1'b0, 33), -1);
    do_op(2'b11, 32'hFFFFFFF9, 32'd2, mk(32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33), -1);
    do_op(2'b10, 32'd7, 32'd2, mk(32'd1, 32'd3, 1'b0, 33), -1);
    do_op(2'b11, 32'h80000000, 32'hFFFFFFFF, mk(32'd0, 32'h80000000, 1'b0, 33), -1);
    do_op(2'b10, 32'hFFFFFFFE, 32'h7FFFFFFF, mk(32'd0, 32'd2, 1'b0, 33), -1);
    do_op(2'b10, 32'd9, 32'd0, mk(32'd9, 32'hFFFFFFFF, 1'b1, 0), -1);
    do_op(2'b00, 32'd6, 32'd7, mk(32'd0, 32'd42, 1'b0, 33), -1);

    // start and MTHI/MTLO mid-run must not disturb the operation
    do_op(2'b00, 32'h12345678, 32'h9ABCDEF0, model(2'b00, 32'h12345678, 32'h9ABCDEF0), 5);

    // Reset in the middle of a DIV
    start = 1'b1; op = 2'b11; a = 32'hFFFFFF9C; b = 32'd7;
    tick();
    start = 1'b0;
    repeat (10) tick();
    reset = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_hi", hi, 0);
    check("abort_lo", lo, 0);
    tick();
    reset = 1'b1;
    extra = 0;
    repeat (40) begin
      tick();
      if (done === 1'b1) extra++;
    end
    check("abort_no_done", extra, 0);
    do_op(2'b00, 32'd100, 32'd3, mk(32'd0, 32'd300, 1'b0, 33), -1);

    // Random operations against the reference model
    for (int i = 0; i < 6; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      if (i == 2) rb = 32'd0;
      do_op(ro, ra, rb, model(ro, ra, rb), -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
